// File: rtl/alu_pkg.sv
// Shared types for the alu_ctrl execute stage: opcodes, FSM states and flag layout.
package alu_pkg;

    // 1000-1111 are reserved: they retire in one cycle with ERR and no side effects.
    typedef enum logic [3:0] {
        OPC_NOP  = 4'b0000,
        OPC_LDI  = 4'b0001,
        OPC_ADD  = 4'b0010,
        OPC_SUB  = 4'b0011,
        OPC_AND  = 4'b0100,
        OPC_OR   = 4'b0101,
        OPC_XOR  = 4'b0110,
        OPC_NOT  = 4'b0111,
        OPC_ILL8 = 4'b1000,
        OPC_ILL9 = 4'b1001,
        OPC_ILLA = 4'b1010,
        OPC_ILLB = 4'b1011,
        OPC_ILLC = 4'b1100,
        OPC_ILLD = 4'b1101,
        OPC_ILLE = 4'b1110,
        OPC_ILLF = 4'b1111
    } opcode_e;

    typedef enum logic [1:0] {
        S_IDLE,
        S_ISSUE,
        S_WAIT,
        S_WB
    } state_e;

    typedef struct packed {
        logic cf;
        logic of;
        logic sf;
        logic zf;
    } flags_t;

    localparam opcode_e OP_NOT = OPC_NOT;
    localparam opcode_e OP_LDI = OPC_LDI;

    function automatic logic is_alu_op(input logic [3:0] op);
        return (op >= OPC_ADD) && (op <= OPC_NOT);
    endfunction

endpackage

// File: rtl/alu_regfile.sv
// Register file for alu_ctrl: two operand read ports, one debug read port,
// one synchronous write port and a synchronous active-low clear.
module alu_regfile #(
    parameter int WIDTH = 8,
    parameter int NREGS = 8,
    localparam int AW = $clog2(NREGS)
) (
    input  logic             CLK,
    input  logic             RST_N,
    input  logic             i_we,
    input  logic [AW-1:0]    i_waddr,
    input  logic [WIDTH-1:0] i_wdata,
    input  logic [AW-1:0]    i_raddr_a,
    input  logic [AW-1:0]    i_raddr_b,
    input  logic [AW-1:0]    i_dbg_addr,
    output logic [WIDTH-1:0] o_rdata_a,
    output logic [WIDTH-1:0] o_rdata_b,
    output logic [WIDTH-1:0] o_dbg_data
);

    logic [WIDTH-1:0] r_mem [NREGS];

    always_ff @(posedge CLK) begin
        if (!RST_N) begin
            for (int i = 0; i < NREGS; i++) r_mem[i] <= '0;
        end else if (i_we) begin
            r_mem[i_waddr] <= i_wdata;
        end
    end

    assign o_rdata_a  = r_mem[i_raddr_a];
    assign o_rdata_b  = r_mem[i_raddr_b];
    assign o_dbg_data = r_mem[i_dbg_addr];

endmodule

// File: rtl/alu_ctrl.sv
// Single-issue execute controller: latches one instruction, sequences the external
// ALU through ISSUE/WAIT, then writes the result and flags back in WB.
module alu_ctrl
    import alu_pkg::*;
#(
    parameter int WIDTH = 8,
    parameter int NREGS = 8,
    localparam int AW = $clog2(NREGS)
) (
    input  logic             CLK,
    input  logic             RST_N,
    input  logic             INSTR_VALID,
    output logic             INSTR_READY,
    input  logic [3:0]       INSTR_OP,
    input  logic [AW-1:0]    INSTR_RD,
    input  logic [AW-1:0]    INSTR_RA,
    input  logic [AW-1:0]    INSTR_RB,
    input  logic [WIDTH-1:0] INSTR_IMM,
    output logic             ALU_EN,
    output logic             ALU_OE,
    output logic [3:0]       ALU_OPCODE,
    output logic [WIDTH-1:0] ALU_A,
    output logic [WIDTH-1:0] ALU_B,
    input  logic [WIDTH-1:0] ALU_OUT,
    input  logic             ALU_CF,
    input  logic             ALU_OF,
    input  logic             ALU_SF,
    input  logic             ALU_ZF,
    output logic [3:0]       FLAGS,
    output logic             DONE,
    output logic             ERR,
    input  logic [AW-1:0]    DBG_ADDR,
    output logic [WIDTH-1:0] DBG_DATA
);

    state_e           r_state, w_next;
    logic [3:0]       r_op;
    logic [AW-1:0]    r_rd, r_ra, r_rb;
    logic [WIDTH-1:0] r_imm, r_result;
    flags_t           r_shadow, r_flags;
    logic             w_accept, w_alu_op, w_we;
    logic [WIDTH-1:0] w_rdata_a, w_rdata_b, w_wdata;

    // Ready is gated by reset so upstream never sees a handshake while held in reset.
    assign INSTR_READY = (r_state == S_IDLE) && RST_N;
    assign w_accept    = INSTR_VALID && INSTR_READY;
    assign w_alu_op    = is_alu_op(r_op);

    always_ff @(posedge CLK) begin
        if (!RST_N) r_state <= S_IDLE;
        else        r_state <= w_next;
    end

    always_comb begin
        w_next     = r_state;
        ALU_EN     = 1'b0;
        ALU_OE     = 1'b0;
        ALU_OPCODE = '0;
        ALU_A      = '0;
        ALU_B      = '0;
        DONE       = 1'b0;
        ERR        = 1'b0;
        case (r_state)
            S_IDLE: begin
                if (w_accept) w_next = is_alu_op(INSTR_OP) ? S_ISSUE : S_WB;
            end
            S_ISSUE: begin
                w_next     = S_WAIT;
                ALU_EN     = 1'b1;
                ALU_OPCODE = r_op;
                ALU_A      = w_rdata_a;
                ALU_B      = (r_op == OP_NOT) ? '0 : w_rdata_b;
            end
            S_WAIT: begin
                w_next = S_WB;
                ALU_OE = 1'b1;
            end
            S_WB: begin
                w_next = S_IDLE;
                DONE   = 1'b1;
                ERR    = r_op[3];
            end
            default: w_next = S_IDLE;
        endcase
    end

    always_ff @(posedge CLK) begin
        if (!RST_N) begin
            r_op  <= '0;
            r_rd  <= '0;
            r_ra  <= '0;
            r_rb  <= '0;
            r_imm <= '0;
        end else if (w_accept) begin
            r_op  <= INSTR_OP;
            r_rd  <= INSTR_RD;
            r_ra  <= INSTR_RA;
            r_rb  <= INSTR_RB;
            r_imm <= INSTR_IMM;
        end
    end

    // Result and flags are only trusted while OE is high, hence the WAIT-only sample.
    always_ff @(posedge CLK) begin
        if (!RST_N) begin
            r_result <= '0;
            r_shadow <= '0;
            r_flags  <= '0;
        end else begin
            if (r_state == S_WAIT) begin
                r_result <= ALU_OUT;
                r_shadow <= {ALU_CF, ALU_OF, ALU_SF, ALU_ZF};
            end
            if ((r_state == S_WB) && w_alu_op) r_flags <= r_shadow;
        end
    end

    assign FLAGS   = r_flags;
    assign w_we    = (r_state == S_WB) && (w_alu_op || (r_op == OP_LDI));
    assign w_wdata = (r_op == OP_LDI) ? r_imm : r_result;

    alu_regfile #(
        .WIDTH (WIDTH),
        .NREGS (NREGS)
    ) u_regfile (
        .CLK        (CLK),
        .RST_N      (RST_N),
        .i_we       (w_we),
        .i_waddr    (r_rd),
        .i_wdata    (w_wdata),
        .i_raddr_a  (r_ra),
        .i_raddr_b  (r_rb),
        .i_dbg_addr (DBG_ADDR),
        .o_rdata_a  (w_rdata_a),
        .o_rdata_b  (w_rdata_b),
        .o_dbg_data (DBG_DATA)
    );

endmodule

// File: doc/alu_ctrl.md
# alu_ctrl

Single-issue execution controller sitting directly upstream of the `ALU` datapath block. It accepts one instruction at a time over a valid/ready handshake and reads operands from an internal register file. It sequences the `ALU`'s `EN`/`OE`/`OPCODE`/`A`/`B` inputs, samples `ALU_OUT` and the CF/OF/SF/ZF flags, then writes the result back and latches the flags. It turns the combinational-style `ALU` into a usable multi-cycle execute stage.

## Interface
- `WIDTH`, 8, data width; must match `ALU` `WIDTH`.
- `NREGS`, 8, register file depth; address width `AW = $clog2(NREGS)`.
- Clock and reset are decided: one clock, `CLK`; reset `RST_N` is synchronous and active-low.
- `CLK` in 1 — clock; all state changes on rising edge.
- `RST_N` in 1 — synchronous active-low reset.
- `INSTR_VALID` in 1 — instruction present.
- `INSTR_READY` out 1 — controller can accept.
- `INSTR_OP` in 4 — opcode.
- `INSTR_RD` in AW — destination register.
- `INSTR_RA` in AW — source A.
- `INSTR_RB` in AW — source B.
- `INSTR_IMM` in WIDTH — immediate for LDI.
- `ALU_EN` out 1 — drives `ALU` EN.
- `ALU_OE` out 1 — drives `ALU` OE.
- `ALU_OPCODE` out 4 — drives `ALU` OPCODE.
- `ALU_A` out WIDTH — drives `ALU` A.
- `ALU_B` out WIDTH — drives `ALU` B.
- `ALU_OUT` in WIDTH — `ALU` result.
- `ALU_CF`, `ALU_OF`, `ALU_SF`, `ALU_ZF` in 1 each — `ALU` flags.
- `FLAGS` out 4 — registered {CF,OF,SF,ZF} of the last ALU op.
- `DONE` out 1 — one-cycle pulse on instruction retire.
- `ERR` out 1 — one-cycle pulse, with `DONE`, for an illegal opcode.
- `DBG_ADDR` in AW — debug read address.
- `DBG_DATA` out WIDTH — combinational `reg[DBG_ADDR]`.

## Operation
- Opcodes:
  - NOP = 0000.
  - LDI = 0001.
  - ALU ops: ADD = 0010, SUB = 0011, AND = 0100, OR = 0101, XOR = 0110, NOT = 0111.
  - 1000–1111 are illegal.
- FSM states: IDLE, ISSUE, WAIT, WB.
- IDLE:
  - `INSTR_READY` = 1.
  - Accept happens on an edge where `INSTR_VALID` and `INSTR_READY` are both high. All INSTR_* fields are latched at that edge; upstream may change them afterwards.
  - After accept: ALU op → ISSUE; LDI, NOP or illegal → WB.
- ISSUE (1 cycle):
  - `ALU_EN` = 1 and `ALU_OPCODE` = latched op.
  - `ALU_A` = `reg[RA]`.
  - `ALU_B` = `reg[RB]`; forced to 0 for NOT.
  - The `ALU` captures its operands on the closing edge.
- WAIT (1 cycle):
  - `ALU_EN` = 0, `ALU_OE` = 1.
  - `ALU_OUT` and the four flags are sampled into the result register and flag shadow on the closing edge.
- WB (1 cycle):
  - `DONE` = 1.
  - ALU op: `reg[RD]` ← result and `FLAGS` ← shadow, both on the closing edge.
  - LDI: `reg[RD]` ← IMM; `FLAGS` unchanged.
  - NOP: no write.
  - Illegal: `ERR` = 1, no register or flag write.
  - Next state: IDLE.
- Outside ISSUE, `ALU_A`, `ALU_B` and `ALU_OPCODE` are driven to 0.
- RD equal to RA or RB is legal: operands are read in ISSUE, before writeback.
- Arithmetic is done only in the `ALU`; this block applies no width extension or truncation.

## Timing
- Reset (`RST_N` = 0 at an edge):
  - State → IDLE.
  - All registers, `FLAGS`, `DONE`, `ERR`, `ALU_EN`, `ALU_OE` and the ALU_* buses → 0.
  - `INSTR_READY` is 0 while `RST_N` = 0 and 1 in the first cycle after release.
- ALU op latency:
  - Accept at edge E0; ISSUE cycle 1; WAIT cycle 2; WB cycle 3 with `DONE` high.
  - The register is visible on `DBG_DATA` after E3.
  - Next accept is possible at E4, giving one ALU op per 4 cycles.
- LDI/NOP/illegal latency: accept at E0, `DONE` in cycle 1, next accept at E2.
- `INSTR_VALID` held high continuously: exactly one instruction is accepted per IDLE visit; no instruction is dropped or duplicated.
- Reset in any state: the in-flight instruction is aborted with no writeback and no `DONE`.
- `DBG_DATA` during WB returns the old value.

## Structure
- Package `alu_pkg`:
  - `opcode_e` (all 16 encodings named, illegal range documented).
  - `state_e`.
  - `flags_t` packed struct {cf,of,sf,zf}.
  - Constants `OP_NOT` and `OP_LDI`.
- Sub-module `alu_regfile`:
  - `NREGS`×`WIDTH`.
  - Two combinational read ports plus one debug read port.
  - One synchronous write port.
  - Synchronous active-low clear.
- `alu_ctrl` holds the FSM, the instruction latch, the result/flag shadow and the output muxing.

## Test plan
- Reset: hold `RST_N` = 0 for 2 cycles mid-traffic → all outputs 0, `INSTR_READY` = 0, then 1 the cycle after release; `DBG_DATA` = 0 for every address.
- Add: LDI r1=6, LDI r2=5, then ADD r3,r1,r2 → `ALU_EN` high for exactly one cycle with A=6, B=5, OPCODE=0010; `DONE` 3 cycles after accept; r3 = 11; `FLAGS` = ALU flags (0000).
- Add with carry-out: r1=150, r2=106, ADD r3 → r3 = 0; `FLAGS` CF=1, ZF=1 as produced by the `ALU`. Follow with SUB r4 with r1=50, r2=100 → r4 = 206, SF=1.
- Back-to-back: `INSTR_VALID` held high for NOT r5,r6 (r6=37) followed by LDI → r5 = 218; `INSTR_READY` low in cycles 1–3; LDI accepted at E4.
- Illegal opcode 1010 → `DONE` and `ERR` both pulse in cycle 1; registers and `FLAGS` unchanged; a subsequent LDI between two ADDs leaves `FLAGS` at the first ADD's value.
- Reset during WAIT of ADD r3 → r3 stays 0, no `DONE` pulse; normal operation resumes after release.
